// File: rtl/mtl_lcd_scanout.sv
// rtl/mtl_lcd_scanout.sv - MTL LCD scanout: HSD/VSD timing, 2x NES picture fetch and pixel output
// h/v hold the current position; every output register is loaded from the next position (look-ahead).
module mtl_lcd_scanout #(
  parameter int          H_TOTAL    = 1056,
  parameter int          V_TOTAL    = 525,
  parameter int          HS_W       = 30,
  parameter int          VS_W       = 13,
  parameter int          H_ACT0     = 50,
  parameter int          V_ACT0     = 23,
  parameter int          H_ACT      = 800,
  parameter int          V_ACT      = 480,
  parameter int          PIC_X0     = 144,
  parameter logic [23:0] BORDER_RGB = 24'h000000
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_en,
  output logic        o_fb_rd,
  output logic [15:0] o_fb_addr,
  input  logic [23:0] i_fb_rdata,
  output logic        o_hsd,
  output logic        o_vsd,
  output logic [7:0]  o_r,
  output logic [7:0]  o_g,
  output logic [7:0]  o_b,
  output logic        o_frame_start,
  output logic        o_vblank
);

  localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
  localparam logic [10:0] HS_END  = 11'(HS_W);
  localparam logic [10:0] HA_BEG  = 11'(H_ACT0);
  localparam logic [10:0] HA_END  = 11'(H_ACT0 + H_ACT);
  localparam logic [10:0] PIC_BEG = 11'(H_ACT0 + PIC_X0);
  localparam logic [10:0] PIC_END = 11'(H_ACT0 + PIC_X0 + 512);
  localparam logic [10:0] FET_BEG = 11'(H_ACT0 + PIC_X0 - 2);
  localparam logic [10:0] FET_END = 11'(H_ACT0 + PIC_X0 + 510);
  localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0]  VS_END  = 10'(VS_W);
  localparam logic [9:0]  VA_BEG  = 10'(V_ACT0);
  localparam logic [9:0]  VA_END  = 10'(V_ACT0 + V_ACT);

  logic [10:0] h, h_nxt;
  logic [9:0]  v, v_nxt;
  logic        v_act, h_act, pic_col, fetch_col, fetch, px_even;
  logic        rd_prev;
  logic [7:0]  nes_x, nes_y;
  logic [23:0] rgb, rgb_nxt;

  always_comb begin
    h_nxt = h + 11'd1;
    v_nxt = v;
    if (h == H_LAST) begin
      h_nxt = '0;
      v_nxt = (v == V_LAST) ? '0 : v + 10'd1;
    end
  end

  // Decode of the next position; a fetch sits two columns ahead of each even picture column.
  always_comb begin
    v_act     = (v_nxt >= VA_BEG) && (v_nxt < VA_END);
    h_act     = (h_nxt >= HA_BEG) && (h_nxt < HA_END);
    pic_col   = (h_nxt >= PIC_BEG) && (h_nxt < PIC_END);
    fetch_col = (h_nxt >= FET_BEG) && (h_nxt < FET_END) && (h_nxt[0] == FET_BEG[0]);
    fetch     = i_en && v_act && fetch_col;
    px_even   = (h_nxt[0] == PIC_BEG[0]);
    nes_x     = 8'((h_nxt - FET_BEG) >> 1);
    nes_y     = 8'((v_nxt - VA_BEG) >> 1);
  end

  // rd_prev marks that i_fb_rdata carries this NES pixel; without it (i_en was low) show border.
  always_comb begin
    rgb_nxt = '0;
    if (v_act && h_act) begin
      if (!pic_col)     rgb_nxt = BORDER_RGB;
      else if (px_even) rgb_nxt = rd_prev ? i_fb_rdata : BORDER_RGB;
      else              rgb_nxt = rgb;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      h             <= '0;
      v             <= '0;
      o_hsd         <= 1'b0;
      o_vsd         <= 1'b0;
      o_frame_start <= 1'b1;
      o_vblank      <= 1'b1;
      o_fb_rd       <= 1'b0;
      o_fb_addr     <= '0;
      rd_prev       <= 1'b0;
      rgb           <= '0;
    end else begin
      h             <= h_nxt;
      v             <= v_nxt;
      o_hsd         <= (h_nxt >= HS_END);
      o_vsd         <= (v_nxt >= VS_END);
      o_frame_start <= (h_nxt == '0) && (v_nxt == '0);
      o_vblank      <= !v_act;
      o_fb_rd       <= fetch;
      if (fetch) o_fb_addr <= {nes_y, nes_x};
      rd_prev       <= o_fb_rd;
      rgb           <= rgb_nxt;
    end
  end

  assign o_r = rgb[23:16];
  assign o_g = rgb[15:8];
  assign o_b = rgb[7:0];

endmodule

// File: tb/tb_mtl_lcd_scanout.sv
// tb/tb_mtl_lcd_scanout.sv - self-checking bench for mtl_lcd_scanout on a reduced raster
// Picture stays 512 wide; the raster is shrunk so several whole frames fit in a short run.
module tb_mtl_lcd_scanout;

  localparam int HT  = 600;
  localparam int HSW = 10;
  localparam int HA0 = 20;
  localparam int HA  = 560;
  localparam int PX0 = 24;
  localparam int VT  = 12;
  localparam int VSW = 2;
  localparam int VA0 = 3;
  localparam int VA  = 6;
  localparam int PB  = HA0 + PX0;
  localparam logic [23:0] BRD = 24'hA0B0C0;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        en = 1'b1;
  logic        fb_rd;
  logic [15:0] fb_addr;
  logic [23:0] fb_rdata = 24'h0;
  logic        hsd, vsd, frame_start, vblank;
  logic [7:0]  r, g, b;

  int tests = 0;
  int fails = 0;
  int hm = 0;
  int vm = 0;
  int rd_cnt = 0;
  int fs_cnt = 0;
  int bd_cnt = 0;
  logic [23:0] sb[$];

  always #5 clk = ~clk;

  mtl_lcd_scanout #(
    .H_TOTAL(HT), .V_TOTAL(VT), .HS_W(HSW), .VS_W(VSW), .H_ACT0(HA0), .V_ACT0(VA0),
    .H_ACT(HA), .V_ACT(VA), .PIC_X0(PX0), .BORDER_RGB(BRD)
  ) dut (
    .i_clk(clk), .i_rstn(rstn), .i_en(en), .o_fb_rd(fb_rd), .o_fb_addr(fb_addr),
    .i_fb_rdata(fb_rdata), .o_hsd(hsd), .o_vsd(vsd), .o_r(r), .o_g(g), .o_b(b),
    .o_frame_start(frame_start), .o_vblank(vblank)
  );

  function automatic logic [23:0] fb_data(input logic [15:0] a);
    if (a == 16'h0000) return 24'h123456;
    return {a[15:8] ^ 8'h3C, a[7:0], a[15:8] + a[7:0]};
  endfunction

  // Frame buffer: data valid only in the cycle after a read strobe, garbage otherwise.
  always @(posedge clk) fb_rdata <= fb_rd ? fb_data(fb_addr) : 24'hBADBAD;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hm <= 0;
      vm <= 0;
    end else if (hm == HT - 1) begin
      hm <= 0;
      vm <= (vm == VT - 1) ? 0 : vm + 1;
    end else begin
      hm <= hm + 1;
    end
  end

  task automatic summary();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  endtask

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h at h=%0d v=%0d", tag, obs, exp, hm, vm);
    end
    if (fails > 30) summary();
  endtask

  // Per-cycle reference check; fetches push two expected pixels, picture pixels pop them.
  always @(negedge clk) begin
    logic vact, hact, pic, fetch;
    logic [7:0] ny, nx;
    logic [23:0] d;
    if (!rstn) sb.delete();
    vact  = (vm >= VA0) && (vm < VA0 + VA);
    hact  = (hm >= HA0) && (hm < HA0 + HA);
    pic   = (hm >= PB) && (hm < PB + 512);
    fetch = vact && (hm >= PB - 2) && (hm < PB + 510) && (((hm - (PB - 2)) % 2) == 0);
    ny    = 8'((vm - VA0) / 2);
    nx    = 8'((hm - (PB - 2)) / 2);
    chk("hsd", hsd, hm >= HSW);
    chk("vsd", vsd, vm >= VSW);
    chk("frame_start", frame_start, (hm == 0) && (vm == 0));
    chk("vblank", vblank, !vact);
    chk("fb_rd", fb_rd, fetch && en);
    if (fetch) begin
      d = en ? fb_data({ny, nx}) : BRD;
      if (en) chk("fb_addr", fb_addr, {ny, nx});
      sb.push_back(d);
      sb.push_back(d);
    end
    if (vact && pic) begin
      chk("sb_nonempty", sb.size() != 0, 1'b1);
      if (sb.size() != 0) chk("rgb_pic", {r, g, b}, sb.pop_front());
    end else if (vact && hact) begin
      chk("rgb_border", {r, g, b}, BRD);
    end else begin
      chk("rgb_blank", {r, g, b}, 24'h0);
    end
    if (rstn && fb_rd) rd_cnt++;
    if (rstn && frame_start) fs_cnt++;
    if (rstn && vact && hact && ({r, g, b} == BRD)) bd_cnt++;
  end

  task automatic wait_pos(input int v, input int h);
    bit found = 1'b0;
    for (int i = 0; i < 2 * HT * VT && !found; i++) begin
      @(posedge clk);
      #1;
      found = (hm == h) && (vm == v);
    end
    chk("wait_pos", found, 1'b1);
  endtask

  task automatic zero_counts();
    rd_cnt = 0;
    fs_cnt = 0;
    bd_cnt = 0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hsd", hsd, 1'b0);
    chk("rst_frame_start", frame_start, 1'b1);
    chk("rst_vblank", vblank, 1'b1);
    @(negedge clk);
    rstn = 1'b1;

    // first picture pixel pair on lines 3 and 4
    wait_pos(VA0, PB - 2);
    chk("first_rd", fb_rd, 1'b1);
    chk("first_addr", fb_addr, 16'h0000);
    wait_pos(VA0, PB - 1);
    chk("left_border", {r, g, b}, BRD);
    wait_pos(VA0, PB);
    chk("first_px0", {r, g, b}, 24'h123456);
    wait_pos(VA0, PB + 1);
    chk("first_px1", {r, g, b}, 24'h123456);
    wait_pos(VA0 + 1, PB + 1);
    chk("first_px_line2", {r, g, b}, 24'h123456);

    // last picture pixel pair on the last active line
    wait_pos(VA0 + VA - 1, PB + 508);
    chk("last_rd", fb_rd, 1'b1);
    chk("last_addr", fb_addr, 16'h02FF);
    wait_pos(VA0 + VA - 1, PB + 510);
    chk("last_px0", {r, g, b}, 24'h3EFF01);
    wait_pos(VA0 + VA - 1, PB + 511);
    chk("last_px1", {r, g, b}, 24'h3EFF01);
    wait_pos(VA0 + VA - 1, PB + 512);
    chk("right_border", {r, g, b}, BRD);
    wait_pos(VA0 + VA - 1, HA0 + HA + 10);
    chk("hblank_black", {r, g, b}, 24'h0);

    // one full frame with the picture enabled
    wait_pos(0, 0);
    zero_counts();
    wait_pos(0, 0);
    chk("reads_en1", rd_cnt, 24'(256 * VA));
    chk("frames_en1", fs_cnt, 24'd1);
    chk("border_en1", bd_cnt, 24'((HA - 512) * VA));

    // one full frame with the picture disabled
    en = 1'b0;
    zero_counts();
    wait_pos(0, 0);
    chk("reads_en0", rd_cnt, 24'd0);
    chk("frames_en0", fs_cnt, 24'd1);
    chk("border_en0", bd_cnt, 24'(HA * VA));

    en = 1'b1;
    zero_counts();
    wait_pos(0, 0);
    chk("reads_reen", rd_cnt, 24'(256 * VA));

    // mid-frame reset during a picture line
    wait_pos(VA0 + 3, 400);
    rstn = 1'b0;
    #1;
    chk("mid_rst_hsd", hsd, 1'b0);
    chk("mid_rst_vsd", vsd, 1'b0);
    chk("mid_rst_rgb", {r, g, b}, 24'h0);
    chk("mid_rst_fs", frame_start, 1'b1);
    chk("mid_rst_vblank", vblank, 1'b1);
    chk("mid_rst_rd", fb_rd, 1'b0);
    chk("mid_rst_addr", fb_addr, 16'h0000);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    zero_counts();
    chk("post_rst_hsd", hsd, 1'b0);
    wait_pos(VA0, PB - 2);
    chk("post_rst_rd", fb_rd, 1'b1);
    chk("post_rst_addr", fb_addr, 16'h0000);
    wait_pos(0, 0);
    chk("post_rst_reads", rd_cnt, 24'(256 * VA));

    summary();
  end

endmodule

// File: doc/mtl_lcd_scanout.md
Name: mtl_lcd_scanout

Overview:
- Transmit end of the MTL LCD pixel interface.
- Generates HSD/VSD timing for an 800x480 panel inside a 1056x525 raster and fetches NES pixels from the frame-buffer read port.
- Presents the 256x240 NES picture scaled 2x (512x480), centred horizontally, with a fixed border colour elsewhere in the active area.
- Sits between the PPU frame buffer and the MTL_R/G/B/HSD/VSD pins; clocked by the LCD pixel clock.

Parameters:
- H_TOTAL, 1056, pixel clocks per line
- V_TOTAL, 525, lines per frame
- HS_W, 30, HSD low width in clocks
- VS_W, 13, VSD low width in lines
- H_ACT0, 50, first active column
- V_ACT0, 23, first active line
- H_ACT, 800, active columns
- V_ACT, 480, active lines
- PIC_X0, 144, picture offset inside the active columns (picture columns 194..705)
- BORDER_RGB, 24'h000000, colour outside the picture

Ports:
- i_clk  in  1  LCD pixel clock
- i_rstn  in  1  asynchronous active-low reset
- i_en  in  1  picture enable; 0 = border colour and no fetches
- o_fb_rd  out  1  frame-buffer read strobe
- o_fb_addr  out  16  {nes_y[7:0], nes_x[7:0]}
- i_fb_rdata  in  24  RGB, valid exactly 1 cycle after o_fb_rd
- o_hsd  out  1  horizontal sync, active low
- o_vsd  out  1  vertical sync, active low
- o_r / o_g / o_b  out  8 each  pixel colour
- o_frame_start  out  1  one-cycle pulse at position (0,0)
- o_vblank  out  1  high on lines outside V_ACT0..V_ACT0+V_ACT-1

Behaviour:
- Position (h,v):
  - Cycle k after reset release (k=0 is the cycle ending at the first posedge) is position h=k mod H_TOTAL.
  - v increments when h wraps from H_TOTAL-1; v wraps from V_TOTAL-1 to 0.
- Output timing:
  - All outputs are registered and describe position (h,v) during that position's cycle; implement this with look-ahead counters.
  - Zero-latency relation to the external position counter is mandatory.
- Reset (async, immediate):
  - Outputs take the values for position (0,0): o_hsd=0, o_vsd=0, RGB=0, o_frame_start=1, o_vblank=1, o_fb_rd=0, o_fb_addr=0.
- Sync outputs:
  - o_hsd = 0 iff h<HS_W.
  - o_vsd = 0 iff v<VS_W; VSD edges coincide with h=0.
- Active area: h in [H_ACT0, H_ACT0+H_ACT) and v in [V_ACT0, V_ACT0+V_ACT).
  - Outside the active area: RGB = 0.
  - Inside the active area but outside the picture columns: BORDER_RGB.
- Picture area:
  - Picture columns: px = h-(H_ACT0+PIC_X0) in 0..511. Picture rows: py = v-V_ACT0 in 0..479.
  - nes_x = px>>1, nes_y = py>>1.
- Fetch pipeline:
  - For each even px, o_fb_rd=1 for exactly one cycle at h-2 with o_fb_addr={nes_y,nes_x}.
  - i_fb_rdata is captured at h-1 and shown at px and px+1 (held 2 cycles).
  - Both lines of a line pair fetch: 256 reads per picture line, 122880 reads per frame.
  - o_fb_addr holds its last value when o_fb_rd=0.
- i_en=0: no reads; picture columns show BORDER_RGB; sync timing is unaffected.
  - i_en is sampled per NES pixel at fetch time, so no half-pixel tearing.
- o_frame_start is high only at (0,0). o_vblank changes at h=0.
- Widths:
  - h is 11 bits, v is 10 bits.
  - Address arithmetic is unsigned; no wrap occurs in range because parameters satisfy PIC_X0+512≤H_ACT and V_ACT=480.
- Mid-frame reset: counters and pipeline flush; any read in flight is discarded; the frame restarts at (0,0) on release.

Test Plan:
- Release reset, run 2 lines -> o_hsd low 30 clocks per 1056-clock period; the first low cycle is k=0.
- Run 1 frame -> o_vsd low for 13*1056=13728 clocks; period 554400 clocks; o_frame_start pulses once per period; o_vblank high on lines 0..22 and 503..524.
- Line 23, model returns 0x123456 for addr 0x0000 -> o_fb_rd at h=192 with addr 0x0000; RGB 0x123456 at h=194 and 195 on lines 23 and 24; h=193 shows BORDER_RGB.
- Last pixel: line 502 -> read at h=702 with addr 0xEFFF; data shown at h=704 and 705; h=706 shows BORDER_RGB; h=850 shows 0.
- i_en=0 for a full frame -> zero o_fb_rd pulses; all 800x480 active pixels show BORDER_RGB; sync identical; i_en=1 -> 122880 reads per frame.
- Assert reset at line 300, h=400, for 5 clocks -> outputs at (0,0) values immediately; after release the timing restarts at k=0 and the next frame's read addresses start at 0x0000.
